// File: rtl/sr_latch_bank_arbiter_if.sv
// rtl/sr_latch_bank_arbiter_if.sv - requester-side bus of the SR latch bank arbiter
// Purpose: bundles the requester handshake (req/wdata in, grant/done/err/busy out).
// Signals:
//   req   [NREQ]        per-requester write request, level
//   wdata [NREQ*WIDTH]  requester i word at bits [i*WIDTH +: WIDTH]
//   grant [NREQ]        one-hot owner of the current transaction
//   done  [NREQ]        one-cycle pulse to the owner at transaction end
//   err                 one-cycle pulse with done on readback mismatch
//   busy                high whenever a transaction is in flight
// Modports: master = requester side, slave = arbiter side.
interface sr_latch_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic                  busy;

  modport master (output req, output wdata,
                  input  grant, input done, input err, input busy);
  modport slave  (input  req, input wdata,
                  output grant, output done, output err, output busy);
endinterface

// File: rtl/sr_latch_bank_arbiter.sv
// rtl/sr_latch_bank_arbiter.sv - round-robin write arbiter and strobe sequencer for a gated SR latch bank
// Purpose: grants one requester at a time, drives SETUP -> G-strobe -> HOLD on the
// shared latch bank, then reads Q back and reports done/err to the owner.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   bus      requester bus (slave modport): req, wdata, grant, done, err, busy
//   latch_g  common gate to all latches
//   latch_s  per-bit set
//   latch_r  per-bit reset
//   latch_q  Q outputs of the latch bank
module sr_latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int PULSE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  sr_latch_bank_arbiter_if.slave   bus,
  output logic                     latch_g,
  output logic [WIDTH-1:0]         latch_s,
  output logic [WIDTH-1:0]         latch_r,
  input  logic [WIDTH-1:0]         latch_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_CHECK
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  dreg_q, dreg_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              latch_g_q, latch_g_d;
  logic [WIDTH-1:0]  latch_s_q, latch_s_d;
  logic [WIDTH-1:0]  latch_r_q, latch_r_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [WIDTH-1:0]  win_word;

  // Round-robin pick: first asserted req scanning ptr, ptr+1, ... mod NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && bus.req[(int'(ptr_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign win_word = bus.wdata[int'(win_idx)*WIDTH +: WIDTH];

  // Every output is computed here for the cycle after the edge, so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    dreg_d    = dreg_q;
    grant_d   = grant_q;
    done_d    = '0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    latch_g_d = 1'b0;
    latch_s_d = latch_s_q;
    latch_r_d = latch_r_q;

    case (state_q)
      S_IDLE: begin
        grant_d   = '0;
        busy_d    = 1'b0;
        latch_s_d = '0;
        latch_r_d = '0;
        if (win_found) begin
          state_d          = S_SETUP;
          owner_d          = win_idx;
          dreg_d           = win_word;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
          // S and R are complementary from SETUP onward, never both high.
          latch_s_d        = win_word;
          latch_r_d        = ~win_word;
        end
      end

      S_SETUP: begin
        state_d   = S_STROBE;
        cnt_d     = '0;
        latch_g_d = 1'b1;
      end

      S_STROBE: begin
        if (cnt_q == CW'(PULSE_CYC - 1)) begin
          state_d = S_HOLD;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          latch_g_d = 1'b1;
        end
      end

      S_HOLD: begin
        state_d   = S_CHECK;
        latch_s_d = '0;
        latch_r_d = '0;
        done_d    = grant_q;
        // The gate is already closed in HOLD, so Q is the settled value that
        // CHECK sees; sampling it on this edge keeps err registered.
        err_d     = (latch_q != dreg_q);
      end

      S_CHECK: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
      end

      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        busy_d    = 1'b0;
        latch_s_d = '0;
        latch_r_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      dreg_q    <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      latch_g_q <= 1'b0;
      latch_s_q <= '0;
      latch_r_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      dreg_q    <= dreg_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      latch_g_q <= latch_g_d;
      latch_s_q <= latch_s_d;
      latch_r_q <= latch_r_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
  assign latch_g   = latch_g_q;
  assign latch_s   = latch_s_q;
  assign latch_r   = latch_r_q;

endmodule

// File: tb/tb_sr_latch_bank_arbiter.sv
// tb/tb_sr_latch_bank_arbiter.sv - self-checking bench for sr_latch_bank_arbiter
module tb_sr_latch_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int P     = 2;

  logic             clk;
  logic             rst;
  logic             latch_g;
  logic [WIDTH-1:0] latch_s;
  logic [WIDTH-1:0] latch_r;
  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] latch_mem;
  logic [WIDTH-1:0] stuck0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: transaction phase -1 = idle, 0 = setup, 1..P = strobe,
  // P+1 = hold, P+2 = check.
  int               m_phase;
  int               m_owner;
  int               m_ptr;
  logic [WIDTH-1:0] m_dreg;
  logic             m_err;

  int               n_grant, n_done, n_abort;
  logic             prev_g;
  logic [WIDTH-1:0] prev_s, prev_r;
  logic [NREQ-1:0]  prev_grant;

  sr_latch_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  sr_latch_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .PULSE_CYC(P)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .latch_g (latch_g),
    .latch_s (latch_s),
    .latch_r (latch_r),
    .latch_q (latch_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural gated SR latch bank with an optional stuck-at-0 mask on Q.
  initial latch_mem = '0;
  always @(latch_g or latch_s or latch_r) begin
    if (latch_g) latch_mem = (latch_mem & ~latch_r) | latch_s;
  end
  assign latch_q = latch_mem & ~stuck0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    oh2idx = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) oh2idx = i;
  endfunction

  task automatic compare_outputs();
    logic [NREQ-1:0]  eg;
    logic [WIDTH-1:0] es, er;
    bit               act;
    act = (m_phase >= 0);
    eg  = '0;
    if (act) eg[m_owner] = 1'b1;
    es = (act && m_phase <= P + 1) ? m_dreg  : '0;
    er = (act && m_phase <= P + 1) ? ~m_dreg : '0;
    check("grant",   bus.grant, eg);
    check("busy",    bus.busy, act);
    check("latch_g", latch_g, (m_phase >= 1 && m_phase <= P));
    check("latch_s", latch_s, es);
    check("latch_r", latch_r, er);
    check("done",    bus.done, (m_phase == P + 2) ? eg : '0);
    check("err",     bus.err, (m_phase == P + 2) && m_err);
    check("s_and_r_excl", latch_s & latch_r, 0);
    check("grant_onehot", $countones(bus.grant) <= 1, 1);
    check("done_onehot",  $countones(bus.done) <= 1, 1);
    if (prev_g && latch_g) begin
      check("s_stable_g", latch_s, prev_s);
      check("r_stable_g", latch_r, prev_r);
    end
    if (bus.grant != 0 && prev_grant == 0) n_grant++;
    if (bus.done != 0) n_done++;
    prev_g     = latch_g;
    prev_s     = latch_s;
    prev_r     = latch_r;
    prev_grant = bus.grant;
  endtask

  task automatic model_next(input logic r, input logic [NREQ-1:0] rq,
                            input logic [NREQ*WIDTH-1:0] wd);
    if (r) begin
      if (m_phase >= 0 && m_phase <= P + 1) n_abort++;
      m_phase = -1;
      m_ptr   = 0;
      m_dreg  = '0;
      m_err   = 1'b0;
    end else if (m_phase < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (rq[c]) begin
          m_owner = c;
          m_dreg  = wd[c*WIDTH +: WIDTH];
          m_phase = 0;
          break;
        end
      end
    end else if (m_phase == P + 1) begin
      m_err   = (latch_q != m_dreg);
      m_phase = m_phase + 1;
    end else if (m_phase == P + 2) begin
      m_ptr   = (m_owner + 1) % NREQ;
      m_phase = -1;
    end else begin
      m_phase = m_phase + 1;
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs for the next edge.
  task automatic step(input logic r, input logic [NREQ-1:0] rq,
                      input logic [NREQ*WIDTH-1:0] wd);
    compare_outputs();
    rst       = r;
    bus.req   = rq;
    bus.wdata = wd;
    model_next(r, rq, wd);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to_done(input string tag, input int idx, input logic [NREQ-1:0] rq,
                             input logic [NREQ*WIDTH-1:0] wd,
                             output int gcnt, output logic err_at_done, output int owner_seen);
    bit seen;
    seen        = 0;
    gcnt        = 0;
    err_at_done = 1'b0;
    owner_seen  = -1;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (latch_g) gcnt++;
      if (owner_seen < 0 && bus.grant != 0) owner_seen = oh2idx(bus.grant);
      if (bus.done[idx]) begin
        seen        = 1;
        err_at_done = bus.err;
      end
      step(1'b0, rq, wd);
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  initial begin
    int                    gc, ow, ng, last_done, c;
    logic                  e;
    logic [NREQ-1:0]       rq;
    logic [NREQ*WIDTH-1:0] wd;
    logic [NREQ-1:0]       prevg;

    rst = 1'b1; bus.req = '0; bus.wdata = '0; stuck0 = '0;
    m_phase = -1; m_owner = 0; m_ptr = 0; m_dreg = '0; m_err = 1'b0;
    n_grant = 0; n_done = 0; n_abort = 0;
    prev_g = 1'b0; prev_s = '0; prev_r = '0; prev_grant = '0;
    repeat (2) @(negedge clk);

    // Reset state, then single write of 0xA5 from requester 1.
    step(1'b1, '0, '0);
    step(1'b0, '0, '0);
    rq = 4'b0010; wd = {8'h00, 8'h00, 8'hA5, 8'h00};
    run_to_done("t1", 1, rq, wd, gc, e, ow);
    check("t1_owner", ow, 1);
    check("t1_gate_cycles", gc, P);
    check("t1_err", e, 0);
    check("t1_latch_q", latch_q, 8'hA5);
    step(1'b0, '0, '0);

    // All four requesting from reset: rotation 0,1,2,3,0, dones 6 cycles apart.
    wd = {8'h44, 8'h33, 8'h22, 8'h11};
    step(1'b1, '0, '0);
    ng = 0; last_done = -1; prevg = '0;
    for (int k = 0; k < 34; k++) begin
      if (bus.grant != 0 && prevg == 0) begin
        if (ng < 5) check("t2_order", oh2idx(bus.grant), ng % NREQ);
        ng++;
      end
      if (bus.done != 0) begin
        if (last_done >= 0) check("t2_done_spacing", cyc - last_done, P + 4);
        check("t2_readback", latch_q, wd[oh2idx(bus.done)*WIDTH +: WIDTH]);
        last_done = cyc;
      end
      prevg = bus.grant;
      step(1'b0, 4'b1111, wd);
    end
    check("t2_grant_count", ng >= 5, 1);
    repeat (10) step(1'b0, '0, wd);

    // Readback fault: Q bit 3 stuck at 0 while writing 0xFF.
    stuck0 = 8'h08;
    rq = 4'b0010; wd = {8'h00, 8'h00, 8'hFF, 8'h00};
    run_to_done("t3", 1, rq, wd, gc, e, ow);
    check("t3_err_with_done", e, 1);
    check("t3_err_clear", bus.err, 0);
    step(1'b0, '0, wd);
    stuck0 = '0;

    // Reset during STROBE aborts; requester 2 is then served.
    rq = 4'b0100; wd = {8'h00, 8'h3C, 8'h00, 8'h00};
    c = 0;
    while (!latch_g && c < 10) begin step(1'b0, rq, wd); c++; end
    check("t4_in_strobe", latch_g, 1);
    step(1'b1, rq, wd);
    check("t4_rst_grant", bus.grant, 0);
    check("t4_rst_busy",  bus.busy, 0);
    check("t4_rst_g",     latch_g, 0);
    check("t4_rst_done",  bus.done, 0);
    check("t4_rst_s",     latch_s, 0);
    run_to_done("t4", 2, rq, wd, gc, e, ow);
    check("t4_owner", ow, 2);
    check("t4_latch_q", latch_q, 8'h3C);
    step(1'b0, '0, wd);

    // Requester 0 drops req and zeroes wdata during STROBE.
    rq = 4'b0001; wd = {8'h00, 8'h00, 8'h00, 8'h96};
    c = 0;
    while (!latch_g && c < 10) begin step(1'b0, rq, wd); c++; end
    check("t5_in_strobe", latch_g, 1);
    run_to_done("t5", 0, '0, '0, gc, e, ow);
    check("t5_latch_q", latch_q, 8'h96);
    step(1'b0, '0, '0);

    // Random traffic with occasional resets.
    n_grant = 0; n_done = 0; n_abort = 0;
    for (int k = 0; k < 10000; k++) begin
      step(($urandom_range(0, 999) == 0), NREQ'($urandom_range(0, (1 << NREQ) - 1)),
           {$urandom});
    end
    repeat (12) step(1'b0, '0, '0);
    check("rand_done_vs_grant", n_done, n_grant - n_abort);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
